// File: rtl/axi_rt_write_buffer.sv
// Real-time write buffer: holds each sub-burst's W beats locally and only releases
// its AW once the whole burst is buffered, so downstream W can never be stalled.

package axi_rt_pkg;
  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned LenW  = 8;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_rt_write_buffer #(
  parameter int unsigned BufDepth = 16,
  parameter int unsigned AwDepth  = 4,
  parameter type axi_req_t  = axi_rt_pkg::axi_req_t,
  parameter type axi_resp_t = axi_rt_pkg::axi_resp_t,
  parameter type aw_chan_t  = axi_rt_pkg::aw_chan_t,
  parameter type w_chan_t   = axi_rt_pkg::w_chan_t
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  axi_req_t                      slv_req_i,
  output axi_resp_t                     slv_resp_o,
  output axi_req_t                      mst_req_o,
  input  axi_resp_t                     mst_resp_i,
  output logic [$clog2(BufDepth+1)-1:0] w_fill_o,
  output logic [$clog2(BufDepth+1)-1:0] full_bursts_o
);
  localparam int unsigned CntW   = $clog2(BufDepth + 1);
  localparam int unsigned WPtrW  = $clog2(BufDepth);
  localparam int unsigned AwCntW = $clog2(AwDepth + 1);
  localparam int unsigned AwPtrW = (AwDepth > 1) ? $clog2(AwDepth) : 1;

  logic              active_q;
  aw_chan_t          aw_mem [AwDepth];
  logic [AwPtrW-1:0] aw_wptr_q, aw_rptr_q;
  logic [AwCntW-1:0] aw_cnt_q;
  w_chan_t           w_mem [BufDepth];
  logic [WPtrW-1:0]  w_wptr_q, w_rptr_q;
  logic [CntW-1:0]   w_cnt_q, full_bursts_q, w_credit_q;

  aw_chan_t aw_head;
  w_chan_t  w_head;
  logic     aw_full, aw_empty, w_full, w_empty;
  logic     aw_ready_c, w_ready_c, mst_aw_valid_c, mst_w_valid_c;
  logic     aw_push, aw_pop, w_push, w_pop, burst_in, burst_out;

  assign aw_head  = aw_mem[aw_rptr_q];
  assign w_head   = w_mem[w_rptr_q];
  assign aw_full  = (aw_cnt_q == AwCntW'(AwDepth));
  assign aw_empty = (aw_cnt_q == '0);
  assign w_full   = (w_cnt_q == CntW'(BufDepth));
  assign w_empty  = (w_cnt_q == '0);

  // Readys stay low until the first edge after reset release.
  assign aw_ready_c     = active_q && !aw_full;
  assign w_ready_c      = active_q && !w_full;
  assign mst_aw_valid_c = !aw_empty && (full_bursts_q != '0);
  assign mst_w_valid_c  = !w_empty && (w_credit_q != '0);

  assign aw_push   = slv_req_i.aw_valid && aw_ready_c;
  assign w_push    = slv_req_i.w_valid && w_ready_c;
  assign aw_pop    = mst_aw_valid_c && mst_resp_i.aw_ready;
  assign w_pop     = mst_w_valid_c && mst_resp_i.w_ready;
  assign burst_in  = w_push && slv_req_i.w.last;
  assign burst_out = w_pop && w_head.last;

  // AR/R/B forward untouched; only the AW and W channels are intercepted.
  always_comb begin : p_out
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_ready_c;
    slv_resp_o.w_ready  = w_ready_c;
    mst_req_o           = slv_req_i;
    mst_req_o.aw        = aw_head;
    mst_req_o.aw_valid  = mst_aw_valid_c;
    mst_req_o.w         = w_head;
    mst_req_o.w_valid   = mst_w_valid_c;
  end

  assign w_fill_o      = w_cnt_q;
  assign full_bursts_o = full_bursts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_ctrl
    if (!rst_ni) begin
      active_q      <= 1'b0;
      aw_wptr_q     <= '0;
      aw_rptr_q     <= '0;
      aw_cnt_q      <= '0;
      w_wptr_q      <= '0;
      w_rptr_q      <= '0;
      w_cnt_q       <= '0;
      full_bursts_q <= '0;
      w_credit_q    <= '0;
    end else begin
      active_q <= 1'b1;
      if (aw_push) aw_wptr_q <= (aw_wptr_q == AwPtrW'(AwDepth - 1)) ? '0 : aw_wptr_q + AwPtrW'(1);
      if (aw_pop)  aw_rptr_q <= (aw_rptr_q == AwPtrW'(AwDepth - 1)) ? '0 : aw_rptr_q + AwPtrW'(1);
      if (w_push)  w_wptr_q  <= (w_wptr_q == WPtrW'(BufDepth - 1)) ? '0 : w_wptr_q + WPtrW'(1);
      if (w_pop)   w_rptr_q  <= (w_rptr_q == WPtrW'(BufDepth - 1)) ? '0 : w_rptr_q + WPtrW'(1);
      aw_cnt_q      <= aw_cnt_q + AwCntW'(aw_push) - AwCntW'(aw_pop);
      w_cnt_q       <= w_cnt_q + CntW'(w_push) - CntW'(w_pop);
      full_bursts_q <= full_bursts_q + CntW'(burst_in) - CntW'(aw_pop);
      w_credit_q    <= w_credit_q + CntW'(aw_pop) - CntW'(burst_out);
    end
  end

  always_ff @(posedge clk_i) begin : p_mem
    if (aw_push) aw_mem[aw_wptr_q] <= slv_req_i.aw;
    if (w_push)  w_mem[w_wptr_q]   <= slv_req_i.w;
  end

`ifndef SYNTHESIS
  // A full W buffer with nothing complete means a burst longer than the buffer.
  a_w_deadlock: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_full && (full_bursts_q == '0) && (w_credit_q == '0)));
  a_aw_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.aw_valid |-> (int'(slv_req_i.aw.len) < int'(BufDepth)));
  a_fb_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(aw_pop && (full_bursts_q == '0)));
  a_credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(burst_out && (w_credit_q == '0)));
`endif

endmodule

// File: tb/tb_axi_rt_write_buffer.sv
// Directed bench for axi_rt_write_buffer: ordering, backpressure, counters,
// reset mid-operation and AR/R/B pass-through.

module tb_axi_rt_write_buffer;
  import axi_rt_pkg::*;

  localparam int unsigned BufDepth = 4;
  localparam int unsigned AwDepth  = 4;
  localparam int unsigned CntW     = $clog2(BufDepth + 1);

  logic            clk;
  logic            rst_n;
  axi_req_t        slv_req, mst_req;
  axi_resp_t       slv_resp, mst_resp;
  logic [CntW-1:0] w_fill, full_bursts;
  int              checks;
  int              errors;

  axi_rt_write_buffer #(
    .BufDepth (BufDepth),
    .AwDepth  (AwDepth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slv_req_i     (slv_req),
    .slv_resp_o    (slv_resp),
    .mst_req_o     (mst_req),
    .mst_resp_i    (mst_resp),
    .w_fill_o      (w_fill),
    .full_bursts_o (full_bursts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic aw_chan_t mk_aw(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [7:0] len);
    aw_chan_t a;
    a.id    = id;
    a.addr  = addr;
    a.len   = len;
    a.size  = 3'd2;
    a.burst = 2'b01;
    return a;
  endfunction

  function automatic w_chan_t mk_w(input logic [31:0] data, input logic last);
    w_chan_t w;
    w.data = data;
    w.strb = 4'hF;
    w.last = last;
    return w;
  endfunction

  b_chan_t b_exp;
  r_chan_t r_exp;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    slv_req  = '0;
    mst_resp = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_aw_ready", 64'(slv_resp.aw_ready), 64'(0));
    check("rst_w_ready", 64'(slv_resp.w_ready), 64'(0));
    check("rst_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    check("rst_w_valid", 64'(mst_req.w_valid), 64'(0));
    check("rst_w_fill", 64'(w_fill), 64'(0));
    check("rst_full", 64'(full_bursts), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;

    // single burst, address first
    slv_req.aw       = mk_aw(4'd1, 32'h1000, 8'd3);
    slv_req.aw_valid = 1'b1;
    #1 check("s1_aw_ready", 64'(slv_resp.aw_ready), 64'(1));
    tick();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_req.w       = mk_w(32'(32'hA0 + i), i == 3);
      slv_req.w_valid = 1'b1;
      #1 check("s1_aw_held", 64'(mst_req.aw_valid), 64'(0));
      tick();
    end
    slv_req.w_valid = 1'b0;
    #1;
    check("s1_aw_valid", 64'(mst_req.aw_valid), 64'(1));
    check("s1_aw_pay", 64'(mst_req.aw), 64'(mk_aw(4'd1, 32'h1000, 8'd3)));
    check("s1_w_early", 64'(mst_req.w_valid), 64'(0));
    check("s1_fill4", 64'(w_fill), 64'(4));
    check("s1_full1", 64'(full_bursts), 64'(1));
    tick();
    check("s1_aw_done", 64'(mst_req.aw_valid), 64'(0));
    check("s1_full0", 64'(full_bursts), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check("s1_w_valid", 64'(mst_req.w_valid), 64'(1));
      check("s1_w_pay", 64'(mst_req.w), 64'(mk_w(32'(32'hA0 + i), i == 3)));
      check("s1_fill", 64'(w_fill), 64'(4 - i));
      tick();
    end
    check("s1_w_end", 64'(mst_req.w_valid), 64'(0));
    check("s1_fill_end", 64'(w_fill), 64'(0));

    // data before address, plus B pass-through
    for (int i = 0; i < 2; i++) begin
      slv_req.w       = mk_w(32'(32'hC0 + i), i == 1);
      slv_req.w_valid = 1'b1;
      tick();
    end
    slv_req.w_valid = 1'b0;
    #1;
    check("s2_no_aw", 64'(mst_req.aw_valid), 64'(0));
    check("s2_full1", 64'(full_bursts), 64'(1));
    check("s2_no_w", 64'(mst_req.w_valid), 64'(0));
    slv_req.aw       = mk_aw(4'd2, 32'h2000, 8'd1);
    slv_req.aw_valid = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b0;
    b_exp.id          = 4'd2;
    b_exp.resp        = 2'b10;
    mst_resp.b        = b_exp;
    mst_resp.b_valid  = 1'b1;
    slv_req.b_ready   = 1'b1;
    #1;
    check("s2_aw_valid", 64'(mst_req.aw_valid), 64'(1));
    check("s2_aw_pay", 64'(mst_req.aw), 64'(mk_aw(4'd2, 32'h2000, 8'd1)));
    check("s2_w_wait", 64'(mst_req.w_valid), 64'(0));
    check("s2_b_valid", 64'(slv_resp.b_valid), 64'(1));
    check("s2_b_pay", 64'(slv_resp.b), 64'(b_exp));
    check("s2_b_ready", 64'(mst_req.b_ready), 64'(1));
    tick();
    mst_resp.b_valid = 1'b0;
    slv_req.b_ready  = 1'b0;
    check("s2_w0", 64'(mst_req.w), 64'(mk_w(32'hC0, 1'b0)));
    check("s2_w0_valid", 64'(mst_req.w_valid), 64'(1));
    tick();
    check("s2_w1", 64'(mst_req.w), 64'(mk_w(32'hC1, 1'b1)));
    tick();
    check("s2_fill_end", 64'(w_fill), 64'(0));

    // simultaneous counter events
    mst_resp.aw_ready = 1'b0;
    mst_resp.w_ready  = 1'b0;
    slv_req.aw        = mk_aw(4'd4, 32'h3000, 8'd0);
    slv_req.w         = mk_w(32'hE0, 1'b1);
    slv_req.aw_valid  = 1'b1;
    slv_req.w_valid   = 1'b1;
    tick();
    slv_req.aw        = mk_aw(4'd5, 32'h3100, 8'd0);
    slv_req.w         = mk_w(32'hE1, 1'b1);
    mst_resp.aw_ready = 1'b1;
    #1;
    check("s3_full_pre", 64'(full_bursts), 64'(1));
    check("s3_aw4", 64'(mst_req.aw), 64'(mk_aw(4'd4, 32'h3000, 8'd0)));
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_resp.w_ready = 1'b1;
    #1;
    check("s3_full_same", 64'(full_bursts), 64'(1));
    check("s3_aw5_valid", 64'(mst_req.aw_valid), 64'(1));
    check("s3_aw5", 64'(mst_req.aw), 64'(mk_aw(4'd5, 32'h3100, 8'd0)));
    check("s3_we0", 64'(mst_req.w), 64'(mk_w(32'hE0, 1'b1)));
    tick();
    check("s3_full0", 64'(full_bursts), 64'(0));
    check("s3_credit_kept", 64'(mst_req.w_valid), 64'(1));
    check("s3_we1", 64'(mst_req.w), 64'(mk_w(32'hE1, 1'b1)));
    tick();
    check("s3_w_drained", 64'(mst_req.w_valid), 64'(0));
    slv_req.w       = mk_w(32'hF0, 1'b1);
    slv_req.w_valid = 1'b1;
    tick();
    slv_req.w_valid = 1'b0;
    #1;
    check("s3_credit_zero", 64'(mst_req.w_valid), 64'(0));
    check("s3_fill1", 64'(w_fill), 64'(1));
    slv_req.aw       = mk_aw(4'd6, 32'h3200, 8'd0);
    slv_req.aw_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    repeat (3) tick();
    check("s3_fill_end", 64'(w_fill), 64'(0));
    check("s3_full_end", 64'(full_bursts), 64'(0));

    // backpressure on downstream AW
    mst_resp.aw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_req.aw       = mk_aw(4'(i), 32'(32'h4000 + i), 8'd0);
      slv_req.w        = mk_w(32'(32'hB0 + i), 1'b1);
      slv_req.aw_valid = 1'b1;
      slv_req.w_valid  = 1'b1;
      #1 check("s4_w_ready", 64'(slv_resp.w_ready), 64'(1));
      tick();
    end
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    #1;
    check("s4_w_full", 64'(slv_resp.w_ready), 64'(0));
    check("s4_aw_full", 64'(slv_resp.aw_ready), 64'(0));
    check("s4_fill4", 64'(w_fill), 64'(4));
    check("s4_full4", 64'(full_bursts), 64'(4));
    check("s4_w_blocked", 64'(mst_req.w_valid), 64'(0));
    mst_resp.aw_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("s4_aw_valid", 64'(mst_req.aw_valid), 64'(j < 4));
      if (j < 4) check("s4_aw_id", 64'(mst_req.aw.id), 64'(j));
      check("s4_w_valid", 64'(mst_req.w_valid), 64'(j >= 1));
      if (j >= 1) check("s4_w_data", 64'(mst_req.w.data), 64'(32'hB0 + j - 1));
      @(posedge clk);
    end
    #1;
    check("s4_w_end", 64'(mst_req.w_valid), 64'(0));
    check("s4_fill_end", 64'(w_fill), 64'(0));
    check("s4_full_end", 64'(full_bursts), 64'(0));

    // reset in the middle of a partly buffered burst
    mst_resp.aw_ready = 1'b0;
    mst_resp.w_ready  = 1'b0;
    slv_req.aw        = mk_aw(4'd7, 32'h5000, 8'd3);
    slv_req.aw_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_req.w       = mk_w(32'(32'hD0 + i), 1'b0);
      slv_req.w_valid = 1'b1;
      tick();
      slv_req.aw_valid = 1'b0;
    end
    slv_req.w_valid = 1'b0;
    #1 check("s5_fill3", 64'(w_fill), 64'(3));
    rst_n = 1'b0;
    tick();
    check("s5_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    check("s5_w_valid", 64'(mst_req.w_valid), 64'(0));
    check("s5_fill0", 64'(w_fill), 64'(0));
    check("s5_full0", 64'(full_bursts), 64'(0));
    check("s5_w_ready", 64'(slv_resp.w_ready), 64'(0));
    rst_n = 1'b1;
    tick();
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    slv_req.aw        = mk_aw(4'd8, 32'h6000, 8'd0);
    slv_req.w         = mk_w(32'h5A, 1'b1);
    slv_req.aw_valid  = 1'b1;
    slv_req.w_valid   = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    #1;
    check("s5_new_aw", 64'(mst_req.aw), 64'(mk_aw(4'd8, 32'h6000, 8'd0)));
    check("s5_new_aw_valid", 64'(mst_req.aw_valid), 64'(1));
    check("s5_new_fill", 64'(w_fill), 64'(1));
    tick();
    check("s5_new_w", 64'(mst_req.w), 64'(mk_w(32'h5A, 1'b1)));
    check("s5_new_w_valid", 64'(mst_req.w_valid), 64'(1));
    tick();
    check("s5_fill_end", 64'(w_fill), 64'(0));

    // AR/R pass-through
    mst_resp.ar_ready = 1'b1;
    slv_req.ar        = mk_aw(4'd5, 32'h7000, 8'd7);
    slv_req.ar_valid  = 1'b1;
    #1;
    check("s6_ar_valid", 64'(mst_req.ar_valid), 64'(1));
    check("s6_ar_pay", 64'(mst_req.ar), 64'(mk_aw(4'd5, 32'h7000, 8'd7)));
    check("s6_ar_ready", 64'(slv_resp.ar_ready), 64'(1));
    tick();
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r_exp.id         = 4'd5;
      r_exp.data       = 32'(32'h700 + i);
      r_exp.resp       = 2'b00;
      r_exp.last       = (i == 7);
      mst_resp.r       = r_exp;
      mst_resp.r_valid = 1'b1;
      slv_req.r_ready  = ((i % 2) == 1);
      #1;
      check("s6_r_valid", 64'(slv_resp.r_valid), 64'(1));
      check("s6_r_pay", 64'(slv_resp.r), 64'(r_exp));
      check("s6_r_ready", 64'(mst_req.r_ready), 64'((i % 2) == 1));
      tick();
    end
    mst_resp.r_valid = 1'b0;
    slv_req.r_ready  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rt_write_buffer.md
Name: axi_rt_write_buffer

Overview:
- Sits directly downstream of the granular burst splitter in the real-time unit.
- Buffers the W beats of each split sub-burst before that sub-burst's AW is presented downstream.
- As a result, a downstream AW is only issued once all of its write data is locally available, so a slow or stalling manager can never hold the interconnect W channel.
- AR, R and B channels pass through unchanged.

Parameters:
- BufDepth, 16: W beat buffer depth in beats; must be ≥ 2 and ≥ len_limit+1 of the upstream splitter.
- AwDepth, 4: AW buffer depth in entries; must be ≥ 1.
- axi_req_t, logic: AXI request struct.
- axi_resp_t, logic: AXI response struct.
- aw_chan_t, logic: AW payload type.
- w_chan_t, logic: W payload type.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- slv_req_i  in  axi_req_t  request from the burst splitter.
- slv_resp_o  out  axi_resp_t  response to the burst splitter.
- mst_req_o  out  axi_req_t  request to downstream.
- mst_resp_i  in  axi_resp_t  response from downstream.
- w_fill_o  out  $clog2(BufDepth+1)  beats currently held in the W buffer.
- full_bursts_o  out  $clog2(BufDepth+1)  complete bursts buffered whose AW has not yet been issued.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. All state clears on reset: both FIFOs empty, all counters 0.
- Reset values of outputs: all valids and readys 0, w_fill_o=0, full_bursts_o=0.
- Reset mid-operation: any buffered AWs and Ws are discarded; no output glitch is required beyond valids dropping.
- AW buffer (FIFO, AwDepth entries):
  - slv_resp_o.aw_ready = !aw_full.
  - Push on slv aw_valid&aw_ready. Payload is stored unmodified.
- W buffer (FIFO, BufDepth entries):
  - slv_resp_o.w_ready = !w_full.
  - Push on slv w handshake. Payload, including last, is stored unmodified.
  - W beats may arrive before their AW; this is accepted.
- full_bursts_q counter:
  - +1 on a slv W push with last=1.
  - −1 on a downstream AW handshake.
  - Both in the same cycle: unchanged.
- w_credit_q counter (bursts whose AW has issued but whose W is not yet complete downstream):
  - +1 on a downstream AW handshake.
  - −1 on a downstream W handshake with last=1.
  - Both in the same cycle: unchanged.
- Downstream AW:
  - mst_req_o.aw_valid = !aw_empty && full_bursts_q != 0. This is registered-count based, so there is at least 1 cycle from the last W push to aw_valid.
  - mst_req_o.aw = AW FIFO head. Pop on mst aw handshake.
  - Once asserted, aw_valid and the payload are held stable until aw_ready (AXI rule). The count cannot fall without that handshake, so stability holds.
- Downstream W:
  - mst_req_o.w_valid = !w_empty && w_credit_q != 0.
  - mst_req_o.w = W FIFO head. Pop on mst w handshake.
  - W is never issued ahead of its AW.
  - Once valid, W stays valid until handshake: the credit only drops on this channel's own last handshake.
- Ordering: AW order equals W order, so counting last beats associates bursts correctly without IDs.
- Pass-through, purely combinational and zero latency:
  - AR, R and B payloads and valids forward unchanged.
  - ar_ready, r_ready and b_ready forward unchanged.
- Full/empty:
  - W buffer full with no complete burst stored means an AW with len+1 > BufDepth. This is a configuration error. A simulation assertion flags w_full && full_bursts_q==0 && w_credit_q==0.
  - An assertion also flags any slv AW with len ≥ BufDepth.
- Counter widths: $clog2(BufDepth+1). Overflow is impossible because each counted burst occupies ≥ 1 buffer slot. An assertion checks that no counter decrements while at 0.
- w_fill_o is the FIFO usage count.
- full_bursts_o = full_bursts_q.

Test Plan:
- Single burst, data after address: AW len=3, then 4 W beats, mst ready=1 → mst aw_valid rises exactly 1 cycle after the 4th (last) W push; then 4 W beats out with last on beat 4; w_fill_o goes 4→0.
- Data before address: 2 beats (len=1) pushed, then AW → aw_valid the cycle after the AW push; W follows the AW handshake; B from downstream returned unchanged same cycle.
- Backpressure: BufDepth=4, mst aw_ready=0, push 4 single-beat bursts → w_ready=0 after the 4th; full_bursts_o=4. Release aw_ready → 4 AWs issue on consecutive cycles; W beats drain one per cycle; counters end at 0.
- Simultaneous events: W last push and downstream AW handshake in the same cycle with full_bursts_q=1 → full_bursts_q stays 1. AW handshake and W last pop in the same cycle → w_credit_q unchanged.
- Reset mid-operation: assert rst_ni=0 with 3 beats and 1 AW buffered → next clock edge shows all valids 0 and w_fill_o=0; after release, a fresh len=0 burst completes normally.
- Pass-through: AR len=7 id=5 plus 8 R beats → forwarded with zero latency and identical fields; r_ready mirrored combinationally.
